bep_manchester_encode: RTL and testbench

// - Transmit side of the BEP thermostat link: serialises one 192-bit frame, MSB first, as Manchester line code.
// - Feeds the top-level serial_decode / state_machine receive path.
// - Used for loopback self-test and for emulating a thermostat on the bench.
// - Frame layout, first bit to last:

---
 rtl/bep_pkg.sv | 64 ++++++
 rtl/bep_half_bit_timer.sv | 29 ++
 rtl/bep_manchester_encode.sv | 144 ++++++++++++++
 tb/tb_bep_manchester_encode.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bep_pkg.sv
// Shared BEP link definitions: frame constants, field offsets and transmit FSM encodings.
// Field offsets are bit positions within the 192-bit frame (bit 191 is sent first).
package bep_pkg;

    localparam int FRAME_BITS = 192;
    localparam int HALF_BITS  = 2 * FRAME_BITS;

    localparam logic [31:0] KNOWN_PREAMBLE = 32'hAAAAAAAA;
    localparam logic [15:0] KNOWN_TYPE_12  = 16'hD391;
    localparam logic [31:0] KNOWN_CONSTANT = 32'h0DFFFFFE;

    localparam int OFS_PREAMBLE = 160;
    localparam int OFS_TYPE_1   = 144;
    localparam int OFS_ID       = 112;
    localparam int OFS_TYPE_2   = 96;
    localparam int OFS_ROOM     = 80;
    localparam int OFS_SET      = 64;
    localparam int OFS_STATE    = 56;
    localparam int OFS_CONSTANT = 24;
    localparam int OFS_TAIL_1   = 16;
    localparam int OFS_TAIL_2   = 8;
    localparam int OFS_TAIL_3   = 0;

    localparam logic [7:0] LAST_BIT_IDX = 8'(FRAME_BITS - 1);

`ifdef BEP_TX_REPEAT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1
    } tx_state_t;
`endif

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [31:0] thermostat_id,
        input logic [15:0] room_temp,
        input logic [15:0] set_temp,
        input logic [7:0]  state,
        input logic [7:0]  tail_1,
        input logic [7:0]  tail_2,
        input logic [7:0]  tail_3
    );
        logic [FRAME_BITS-1:0] f;
        f                      = '0;
        f[OFS_PREAMBLE +: 32]  = KNOWN_PREAMBLE;
        f[OFS_TYPE_1   +: 16]  = KNOWN_TYPE_12;
        f[OFS_ID       +: 32]  = thermostat_id;
        f[OFS_TYPE_2   +: 16]  = KNOWN_TYPE_12;
        f[OFS_ROOM     +: 16]  = room_temp;
        f[OFS_SET      +: 16]  = set_temp;
        f[OFS_STATE    +: 8]   = state;
        f[OFS_CONSTANT +: 32]  = KNOWN_CONSTANT;
        f[OFS_TAIL_1   +: 8]   = tail_1;
        f[OFS_TAIL_2   +: 8]   = tail_2;
        f[OFS_TAIL_3   +: 8]   = tail_3;
        return f;
    endfunction

endpackage

// File: rtl/bep_half_bit_timer.sv
// Half-bit pacing timer: ticks on the last cycle of each HALF_BIT_CYCLES-long half-bit.
// Held at zero while clear is high, so every frame starts from a fresh half-bit.
module bep_half_bit_timer #(
    parameter int HALF_BIT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int W = $clog2(HALF_BIT_CYCLES);
    localparam logic [W-1:0] LAST = W'(HALF_BIT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = !clear && (count == LAST);

endmodule

// File: rtl/bep_manchester_encode.sv
// BEP link transmitter: serialises a 192-bit frame MSB first as IEEE 802.3 Manchester code.
// Define BEP_TX_REPEAT_EN to add repeat_cnt, IFG_CYCLES and inter-frame gaps between copies.
module bep_manchester_encode
    import bep_pkg::*;
#(
    parameter int HALF_BIT_CYCLES = 16
`ifdef BEP_TX_REPEAT_EN
    ,
    parameter int IFG_CYCLES = 256
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] thermostat_id,
    input  logic [15:0] room_temp,
    input  logic [15:0] set_temp,
    input  logic [7:0]  state,
    input  logic [7:0]  tail_1,
    input  logic [7:0]  tail_2,
    input  logic [7:0]  tail_3,
`ifdef BEP_TX_REPEAT_EN
    input  logic [1:0]  repeat_cnt,
`endif
    output logic        manchester_out,
    output logic        busy,
    output logic        done
);

    logic [FRAME_BITS-1:0] frame_in;
    logic [FRAME_BITS-1:0] shreg;
    logic [7:0]            bit_idx;
    logic                  phase;
    logic                  tick;
    tx_state_t             fsm_state;

`ifdef BEP_TX_REPEAT_EN
    localparam int GAP_W = $clog2(IFG_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);

    logic [1:0]       rep_left;
    logic [GAP_W-1:0] gap_cnt;
`endif

    assign frame_in = build_frame(thermostat_id, room_temp, set_temp, state,
                                  tail_1, tail_2, tail_3);

    bep_half_bit_timer #(
        .HALF_BIT_CYCLES(HALF_BIT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(fsm_state != ST_SEND),
        .tick (tick)
    );

    // The shift register rotates rather than shifts, so after 192 bits it holds the
    // captured frame again and a repeated copy needs no second storage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_state      <= ST_IDLE;
            shreg          <= '0;
            bit_idx        <= '0;
            phase          <= 1'b0;
            manchester_out <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef BEP_TX_REPEAT_EN
            rep_left       <= '0;
            gap_cnt        <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (fsm_state)
                ST_IDLE: begin
                    if (start && !busy) begin
                        shreg          <= frame_in;
                        bit_idx        <= LAST_BIT_IDX;
                        phase          <= 1'b0;
                        manchester_out <= ~frame_in[FRAME_BITS-1];
                        busy           <= 1'b1;
                        fsm_state      <= ST_SEND;
`ifdef BEP_TX_REPEAT_EN
                        rep_left       <= repeat_cnt;
`endif
                    end
                end

                ST_SEND: begin
                    if (tick) begin
                        if (!phase) begin
                            phase          <= 1'b1;
                            manchester_out <= shreg[FRAME_BITS-1];
                        end else begin
                            phase <= 1'b0;
                            shreg <= {shreg[FRAME_BITS-2:0], shreg[FRAME_BITS-1]};
                            if (bit_idx != 8'd0) begin
                                bit_idx        <= bit_idx - 8'd1;
                                manchester_out <= ~shreg[FRAME_BITS-2];
                            end else begin
                                manchester_out <= 1'b0;
`ifdef BEP_TX_REPEAT_EN
                                if (rep_left != 2'd0) begin
                                    rep_left  <= rep_left - 2'd1;
                                    gap_cnt   <= '0;
                                    fsm_state <= ST_GAP;
                                end else begin
                                    busy      <= 1'b0;
                                    done      <= 1'b1;
                                    fsm_state <= ST_IDLE;
                                end
`else
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                fsm_state <= ST_IDLE;
`endif
                            end
                        end
                    end
                end

`ifdef BEP_TX_REPEAT_EN
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        bit_idx        <= LAST_BIT_IDX;
                        phase          <= 1'b0;
                        manchester_out <= ~shreg[FRAME_BITS-1];
                        fsm_state      <= ST_SEND;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
`endif

                default: begin
                    manchester_out <= 1'b0;
                    busy           <= 1'b0;
                    fsm_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bep_manchester_encode.sv
// Self-checking bench for bep_manchester_encode against a frame-level Manchester reference model.
// Covers the BEP_TX_REPEAT_EN build as well when that macro is defined.
module tb_bep_manchester_encode;

    localparam int HB        = 4;
    localparam int IFG       = 20;
    localparam int FRAME_CYC = 384 * HB;
    localparam int MAX_CAP   = 3 * FRAME_CYC + 2 * IFG + 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] thermostat_id = '0;
    logic [15:0] room_temp = '0;
    logic [15:0] set_temp = '0;
    logic [7:0]  state = '0;
    logic [7:0]  tail_1 = '0;
    logic [7:0]  tail_2 = '0;
    logic [7:0]  tail_3 = '0;
`ifdef BEP_TX_REPEAT_EN
    logic [1:0]  repeat_cnt = '0;
`endif
    logic        manchester_out;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;

    logic wave[MAX_CAP];
    logic bsy[MAX_CAP];
    logic dn[MAX_CAP];

    bep_manchester_encode #(
        .HALF_BIT_CYCLES(HB)
`ifdef BEP_TX_REPEAT_EN
        ,
        .IFG_CYCLES(IFG)
`endif
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .thermostat_id (thermostat_id),
        .room_temp     (room_temp),
        .set_temp      (set_temp),
        .state         (state),
        .tail_1        (tail_1),
        .tail_2        (tail_2),
        .tail_3        (tail_3),
`ifdef BEP_TX_REPEAT_EN
        .repeat_cnt    (repeat_cnt),
`endif
        .manchester_out(manchester_out),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Reference frame straight from the documented field layout.
    function automatic logic [191:0] ref_frame();
        return {32'hAAAAAAAA, 16'hD391, thermostat_id, 16'hD391, room_temp,
                set_temp, state, 32'h0DFFFFFE, tail_1, tail_2, tail_3};
    endfunction

    // Line level in cycle cyc of a frame: bit 1 = low,high; bit 0 = high,low.
    function automatic logic ref_level(input logic [191:0] f, input int cyc);
        int   h;
        logic b;
        h = cyc / HB;
        b = f[191 - h / 2];
        return (h % 2 == 0) ? ~b : b;
    endfunction

    function automatic int wave_errors(input logic [191:0] f, input int base);
        int e;
        e = 0;
        for (int i = 0; i < FRAME_CYC; i++)
            if (wave[base + i] !== ref_level(f, i)) e++;
        return e;
    endfunction

    function automatic int busy_errors(input int base, input int n);
        int e;
        e = 0;
        for (int i = 0; i < n; i++)
            if (bsy[base + i] !== 1'b1 || dn[base + i] !== 1'b0) e++;
        return e;
    endfunction

    function automatic int done_count(input int base, input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++)
            if (dn[base + i] === 1'b1) c++;
        return c;
    endfunction

    function automatic logic [191:0] decode(input int base);
        logic [191:0] d;
        logic a, b;
        for (int k = 0; k < 192; k++) begin
            a = wave[base + 2 * k * HB + HB / 2];
            b = wave[base + (2 * k + 1) * HB + HB / 2];
            d[191 - k] = (a === 1'b0 && b === 1'b1) ? 1'b1 :
                         ((a === 1'b1 && b === 1'b0) ? 1'b0 : 1'bx);
        end
        return d;
    endfunction

    task automatic scramble_fields();
        thermostat_id = $urandom;
        room_temp     = 16'($urandom);
        set_temp      = 16'($urandom);
        state         = 8'($urandom);
        tail_1        = 8'($urandom);
        tail_2        = 8'($urandom);
        tail_3        = 8'($urandom);
    endtask

    task automatic capture(input int from, input int n);
        for (int i = 0; i < n; i++) begin
            wave[from + i] = manchester_out;
            bsy[from + i]  = busy;
            dn[from + i]   = done;
            @(negedge clk);
        end
    endtask

    // Pulses start for one cycle; returns on the first busy cycle with fields scrambled.
    task automatic launch(output logic pre_busy);
        @(negedge clk);
        pre_busy = busy;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble_fields();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (manchester_out !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_line got=%b want=0", manchester_out);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy);
        end
        total++;
        if (done !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_done got=%b want=0", done);
        end
        rst_n = 1'b1;
        capture(0, 8);
        total++;
        if (done_count(0, 8) != 0 || wave[7] !== 1'b0 || bsy[7] !== 1'b0) begin
            bad++; $display("[TB] FAIL idle_after_reset line=%b busy=%b want 0,0", wave[7], bsy[7]);
        end
    endtask

    task automatic test_latency();
        logic [191:0] f;
        logic pre;
        int pe, di;
        scramble_fields();
        f = ref_frame();
        launch(pre);
        capture(0, FRAME_CYC + 4);
        total++;
        if (pre !== 1'b0 || bsy[0] !== 1'b1) begin
            bad++; $display("[TB] FAIL busy_rise before=%b after=%b want 0,1", pre, bsy[0]);
        end
        pe = 0;
        for (int i = 0; i < 16 * HB; i++)
            if (wave[i] !== (((i / HB) % 4 == 1) || ((i / HB) % 4 == 2))) pe++;
        total++;
        if (pe != 0) begin
            bad++; $display("[TB] FAIL preamble_0110 errors=%0d want 0", pe);
        end
        di = -1;
        for (int i = FRAME_CYC + 3; i >= 0; i--)
            if (dn[i] === 1'b1) di = i;
        total++;
        if (di != FRAME_CYC) begin
            bad++; $display("[TB] FAIL done_latency got=%0d want=%0d", di, FRAME_CYC);
        end
        total++;
        if (busy_errors(0, FRAME_CYC) != 0) begin
            bad++; $display("[TB] FAIL busy_during_frame errors=%0d want 0", busy_errors(0, FRAME_CYC));
        end
    endtask

    task automatic test_known_frame();
        logic [191:0] f, d;
        logic pre;
        thermostat_id = 32'h12345678;
        room_temp = 16'h00D2;
        set_temp = 16'h00C8;
        state = 8'h01;
        tail_1 = 8'hA5;
        tail_2 = 8'h5A;
        tail_3 = 8'h3C;
        f = ref_frame();
        launch(pre);
        capture(0, FRAME_CYC + 2);
        d = decode(0);
        total++;
        if (d !== f) begin
            bad++; $display("[TB] FAIL known_decode got=%h want=%h", d, f);
        end
        total++;
        if (wave_errors(f, 0) != 0) begin
            bad++; $display("[TB] FAIL known_wave errors=%0d want 0", wave_errors(f, 0));
        end
        total++;
        if (wave[FRAME_CYC] !== 1'b0 || bsy[FRAME_CYC] !== 1'b0 || dn[FRAME_CYC] !== 1'b1) begin
            bad++; $display("[TB] FAIL known_end line=%b busy=%b done=%b want 0,0,1",
                            wave[FRAME_CYC], bsy[FRAME_CYC], dn[FRAME_CYC]);
        end
        total++;
        if (dn[FRAME_CYC + 1] !== 1'b0) begin
            bad++; $display("[TB] FAIL known_done_pulse got=%b want=0", dn[FRAME_CYC + 1]);
        end
    endtask

    task automatic test_random_frames();
        logic [191:0] f, d;
        logic pre;
        for (int n = 0; n < 3; n++) begin
            scramble_fields();
            f = ref_frame();
            launch(pre);
            capture(0, FRAME_CYC + 2);
            d = decode(0);
            total++;
            if (d !== f || wave_errors(f, 0) != 0) begin
                bad++; $display("[TB] FAIL random_frame%0d got=%h want=%h wave_err=%0d",
                                n, d, f, wave_errors(f, 0));
            end
            total++;
            if (done_count(0, FRAME_CYC + 2) != 1 || dn[FRAME_CYC] !== 1'b1) begin
                bad++; $display("[TB] FAIL random_done%0d pulses=%0d want 1", n,
                                done_count(0, FRAME_CYC + 2));
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [191:0] f;
        logic pre;
        int extra;
        scramble_fields();
        f = ref_frame();
        launch(pre);
        capture(0, 600);
        start = 1'b1;
        scramble_fields();
        capture(600, 1);
        start = 1'b0;
        capture(601, FRAME_CYC + 20 - 601);
        total++;
        if (wave_errors(f, 0) != 0) begin
            bad++; $display("[TB] FAIL ignore_wave errors=%0d want 0", wave_errors(f, 0));
        end
        extra = 0;
        for (int i = FRAME_CYC; i < FRAME_CYC + 20; i++)
            if (bsy[i] !== 1'b0) extra++;
        total++;
        if (extra != 0 || done_count(0, FRAME_CYC + 20) != 1) begin
            bad++; $display("[TB] FAIL ignore_no_extra busy_cycles=%0d done_pulses=%0d want 0,1",
                            extra, done_count(0, FRAME_CYC + 20));
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [191:0] f;
        logic pre;
        int dc, bc;
        scramble_fields();
        f = ref_frame();
        launch(pre);
        capture(0, 733);
        total++;
        if (wave[732] !== ref_level(f, 732) || manchester_out !== 1'b1) begin
            bad++; $display("[TB] FAIL bit100_level got=%b want=1", manchester_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (manchester_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_abort line=%b busy=%b done=%b want 0,0,0",
                            manchester_out, busy, done);
        end
        dc = 0;
        bc = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) dc++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done !== 1'b0) dc++;
            if (busy !== 1'b0 || manchester_out !== 1'b0) bc++;
        end
        total++;
        if (dc != 0 || bc != 0) begin
            bad++; $display("[TB] FAIL reset_no_done done_cycles=%0d active_cycles=%0d want 0,0", dc, bc);
        end
    endtask

    task automatic test_back_to_back();
        logic [191:0] fa, fb;
        @(negedge clk);
        scramble_fields();
        fa = ref_frame();
        start = 1'b1;
        @(negedge clk);
        scramble_fields();
        fb = ref_frame();
        capture(0, FRAME_CYC + 1);
        capture(FRAME_CYC + 1, FRAME_CYC);
        total++;
        if (wave_errors(fa, 0) != 0) begin
            bad++; $display("[TB] FAIL b2b_first errors=%0d want 0", wave_errors(fa, 0));
        end
        total++;
        if (dn[FRAME_CYC] !== 1'b1 || bsy[FRAME_CYC] !== 1'b0) begin
            bad++; $display("[TB] FAIL b2b_handover done=%b busy=%b want 1,0", dn[FRAME_CYC], bsy[FRAME_CYC]);
        end
        total++;
        if (wave_errors(fb, FRAME_CYC + 1) != 0 || busy_errors(FRAME_CYC + 1, FRAME_CYC) != 0) begin
            bad++; $display("[TB] FAIL b2b_second wave_err=%0d busy_err=%0d want 0,0",
                            wave_errors(fb, FRAME_CYC + 1), busy_errors(FRAME_CYC + 1, FRAME_CYC));
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || manchester_out !== 1'b0) begin
            bad++; $display("[TB] FAIL b2b_end done=%b busy=%b line=%b want 1,0,0", done, busy, manchester_out);
        end
        start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("[TB] FAIL b2b_stop busy=%b done=%b want 0,0", busy, done);
        end
    endtask

`ifdef BEP_TX_REPEAT_EN
    task automatic test_repeat();
        logic [191:0] f;
        logic pre;
        logic exp;
        int span, we, off;
        span = 3 * FRAME_CYC + 2 * IFG;
        scramble_fields();
        repeat_cnt = 2'd2;
        f = ref_frame();
        launch(pre);
        repeat_cnt = 2'd0;
        capture(0, span + 2);
        we = 0;
        for (int i = 0; i < span; i++) begin
            off = i % (FRAME_CYC + IFG);
            exp = (off < FRAME_CYC) ? ref_level(f, off) : 1'b0;
            if (wave[i] !== exp) we++;
        end
        total++;
        if (we != 0) begin
            bad++; $display("[TB] FAIL repeat_wave errors=%0d want 0", we);
        end
        total++;
        if (busy_errors(0, span) != 0) begin
            bad++; $display("[TB] FAIL repeat_busy errors=%0d want 0", busy_errors(0, span));
        end
        total++;
        if (dn[span] !== 1'b1 || bsy[span] !== 1'b0 || done_count(0, span + 2) != 1) begin
            bad++; $display("[TB] FAIL repeat_done at_end=%b pulses=%0d want 1,1", dn[span],
                            done_count(0, span + 2));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_known_frame();
        test_random_frames();
        test_ignore_start();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef BEP_TX_REPEAT_EN
        test_repeat();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
